// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared types and helpers for the systolic array controller.
//   state_t        : 2-bit controller state encoding
//   calc_t_total() : number of RUN cycles needed to stream every operand
//                    through the skewed array and drain the PE pipeline
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The last operand enters the far corner PE at (a_rows-1)+(b_cols-1)+(a_cols-1),
    // and its product needs pe_lat more cycles to land in the accumulator.
    function automatic int calc_t_total(input int a_rows, input int a_cols,
                                        input int b_cols, input int pe_lat);
        return a_cols + a_rows + b_cols - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// systolic_skew_lane
// One edge lane of the systolic array: produces the operand-valid and the
// k index for a single row (or column) that is delayed by OFFSET cycles.
// Purely combinational; the top registers the result.
// Ports:
//   in_run : controller is (about to be) in RUN
//   t      : RUN cycle counter
//   valid  : operand for this lane is valid this cycle
//   idx    : k index (t - OFFSET) when valid, else 0
module systolic_skew_lane #(
    parameter int OFFSET = 0,
    parameter int N      = 4,
    parameter int T_W    = 4,
    parameter int IDX_W  = 2
) (
    input  logic             in_run,
    input  logic [T_W-1:0]   t,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [T_W-1:0] FIRST_T = T_W'(OFFSET);
    localparam logic [T_W-1:0] LAST_T  = T_W'(OFFSET + N - 1);

    logic lower_ok;

    // Lane 0 has no lower bound; comparing an unsigned count against 0 would
    // be a constant expression.
    generate
        if (OFFSET == 0) begin : g_no_lower
            assign lower_ok = 1'b1;
        end else begin : g_lower
            assign lower_ok = (t >= FIRST_T);
        end
    endgenerate

    always_comb begin
        valid = in_run && lower_ok && (t <= LAST_T);
        idx   = '0;
        if (valid) begin
            idx = IDX_W'(t - FIRST_T);
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl
// Sequencer for an A_ROWS x B_COLS output-stationary systolic array.
// Clears the accumulators, streams skewed operand indices into the left
// (A) and top (B) edges, waits for the PE pipeline to drain, then flags the
// result matrix as readable.
//
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to add perf_runs/perf_busy.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : request one multiply (honoured only in IDLE)
//   busy             : multiply in progress (CLEAR, RUN, DONE)
//   pe_clear         : clear all PE accumulators
//   a_valid, a_idx   : per-row operand valid and k index (IDX_W per row)
//   b_valid, b_idx   : per-column operand valid and k index
//   done             : one-cycle pulse when results are final
//   result_valid     : result matrix stable; held until the next CLEAR
//   perf_runs        : (PERF_EN) completed runs, wrapping
//   perf_busy        : (PERF_EN) busy cycles, saturating
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | one cycle clearing PE accumulators
// RUN     | streaming operands, t = 0 .. T_TOTAL-1
// DONE    | one cycle, done pulse, results now valid
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int A_ROWS = 4,
    parameter int A_COLS = 4,
    parameter int B_COLS = 4,
    parameter int PE_LAT = 1,
    parameter int IDX_W  = (A_COLS > 1) ? $clog2(A_COLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     pe_clear,
    output logic [A_ROWS-1:0]        a_valid,
    output logic [A_ROWS*IDX_W-1:0]  a_idx,
    output logic [B_COLS-1:0]        b_valid,
    output logic [B_COLS*IDX_W-1:0]  b_idx,
    output logic                     done,
    output logic                     result_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]              perf_runs,
    output logic [31:0]              perf_busy
`endif
);

    localparam int T_TOTAL = calc_t_total(A_ROWS, A_COLS, B_COLS, PE_LAT);
    localparam int T_W     = (T_TOTAL > 1) ? $clog2(T_TOTAL) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(T_TOTAL - 1);

    state_t         state, state_nx;
    logic [T_W-1:0] t, t_nx;
    logic           run_nx;

    logic [A_ROWS-1:0]       a_valid_nx;
    logic [A_ROWS*IDX_W-1:0] a_idx_nx;
    logic [B_COLS-1:0]       b_valid_nx;
    logic [B_COLS*IDX_W-1:0] b_idx_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            t     <= '0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
        end
    end

    always_comb begin
        state_nx = state;
        t_nx     = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (t == T_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    t_nx = t + 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Lanes look at the next-state counter so that the registered outputs
    // line up with the cycle in which t holds that value.
    assign run_nx = (state_nx == ST_RUN);

    generate
        for (genvar i = 0; i < A_ROWS; i++) begin : g_row
            systolic_skew_lane #(
                .OFFSET (i),
                .N      (A_COLS),
                .T_W    (T_W),
                .IDX_W  (IDX_W)
            ) u_lane (
                .in_run (run_nx),
                .t      (t_nx),
                .valid  (a_valid_nx[i]),
                .idx    (a_idx_nx[i*IDX_W +: IDX_W])
            );
        end
        for (genvar j = 0; j < B_COLS; j++) begin : g_col
            systolic_skew_lane #(
                .OFFSET (j),
                .N      (A_COLS),
                .T_W    (T_W),
                .IDX_W  (IDX_W)
            ) u_lane (
                .in_run (run_nx),
                .t      (t_nx),
                .valid  (b_valid_nx[j]),
                .idx    (b_idx_nx[j*IDX_W +: IDX_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            pe_clear     <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            a_valid      <= '0;
            a_idx        <= '0;
            b_valid      <= '0;
            b_idx        <= '0;
        end else begin
            busy     <= (state_nx != ST_IDLE);
            pe_clear <= (state_nx == ST_CLEAR);
            done     <= (state_nx == ST_DONE);
            if (state_nx == ST_DONE) begin
                result_valid <= 1'b1;
            end else if (state_nx == ST_CLEAR) begin
                result_valid <= 1'b0;
            end
            a_valid <= a_valid_nx;
            a_idx   <= a_idx_nx;
            b_valid <= b_valid_nx;
            b_idx   <= b_idx_nx;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_runs <= '0;
            perf_busy <= '0;
        end else begin
            if (done) begin
                perf_runs <= perf_runs + 16'd1;
            end
            if (busy && (perf_busy != 32'hFFFF_FFFF)) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl
// Scoreboard bench for systolic_ctrl at A_ROWS=A_COLS=B_COLS=4, PE_LAT=1.
// A phase-based reference model pushes the expected outputs for every cycle
// when the inputs are driven; the monitor pops and compares on the falling
// edge. Build with SYSTOLIC_CTRL_PERF_EN to also cover the perf counters.
module tb_systolic_ctrl;

    localparam int A_ROWS  = 4;
    localparam int A_COLS  = 4;
    localparam int B_COLS  = 4;
    localparam int PE_LAT  = 1;
    localparam int IDX_W   = 2;
    localparam int T_TOTAL = A_COLS + A_ROWS + B_COLS - 2 + PE_LAT;
    localparam int PH_DONE = T_TOTAL + 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    busy;
    logic                    pe_clear;
    logic [A_ROWS-1:0]       a_valid;
    logic [A_ROWS*IDX_W-1:0] a_idx;
    logic [B_COLS-1:0]       b_valid;
    logic [B_COLS*IDX_W-1:0] b_idx;
    logic                    done;
    logic                    result_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]             perf_runs;
    logic [31:0]             perf_busy;
`endif

    always #5 clk = ~clk;

    systolic_ctrl #(
        .A_ROWS (A_ROWS),
        .A_COLS (A_COLS),
        .B_COLS (B_COLS),
        .PE_LAT (PE_LAT),
        .IDX_W  (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .pe_clear     (pe_clear),
        .a_valid      (a_valid),
        .a_idx        (a_idx),
        .b_valid      (b_valid),
        .b_idx        (b_idx),
        .done         (done),
        .result_valid (result_valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_runs    (perf_runs),
        .perf_busy    (perf_busy)
`endif
    );

    typedef struct packed {
        logic                    busy;
        logic                    pe_clear;
        logic                    done;
        logic                    rv;
        logic [A_ROWS-1:0]       av;
        logic [A_ROWS*IDX_W-1:0] ai;
        logic [B_COLS-1:0]       bv;
        logic [B_COLS*IDX_W-1:0] bi;
        logic [15:0]             runs;
        logic [31:0]             bcyc;
    } exp_t;

    exp_t sb_q[$];

    // Model: ph = cycles since the start-sampling edge (0 = idle).
    int   ph;
    logic m_rv;
    int   m_runs;
    int   m_busy;
    int   n_checks;
    int   n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic rs);
        if (rs) begin
            m_runs = 0;
            m_busy = 0;
            ph     = 0;
            m_rv   = 1'b0;
        end else begin
            if (ph != 0) m_busy++;
            if (ph == PH_DONE) m_runs = (m_runs + 1) % 65536;
            if (ph == 0) begin
                if (st) ph = 1;
            end else if (ph == PH_DONE) begin
                ph = 0;
            end else begin
                ph++;
            end
            if (ph == 1) m_rv = 1'b0;
            if (ph == PH_DONE) m_rv = 1'b1;
        end
    endtask

    function automatic exp_t build_exp();
        exp_t e;
        int   tt;
        e          = '0;
        e.busy     = (ph != 0);
        e.pe_clear = (ph == 1);
        e.done     = (ph == PH_DONE);
        e.rv       = m_rv;
        e.runs     = 16'(m_runs);
        e.bcyc     = 32'(m_busy);
        if (ph >= 2 && ph <= T_TOTAL + 1) begin
            tt = ph - 2;
            for (int i = 0; i < A_ROWS; i++) begin
                if (tt - i >= 0 && tt - i <= A_COLS - 1) begin
                    e.av[i] = 1'b1;
                    e.ai[i*IDX_W +: IDX_W] = IDX_W'(tt - i);
                end
            end
            for (int j = 0; j < B_COLS; j++) begin
                if (tt - j >= 0 && tt - j <= A_COLS - 1) begin
                    e.bv[j] = 1'b1;
                    e.bi[j*IDX_W +: IDX_W] = IDX_W'(tt - j);
                end
            end
        end
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk("busy",         64'(busy),         64'(e.busy));
            chk("pe_clear",     64'(pe_clear),     64'(e.pe_clear));
            chk("done",         64'(done),         64'(e.done));
            chk("result_valid", 64'(result_valid), 64'(e.rv));
            chk("a_valid",      64'(a_valid),      64'(e.av));
            chk("a_idx",        64'(a_idx),        64'(e.ai));
            chk("b_valid",      64'(b_valid),      64'(e.bv));
            chk("b_idx",        64'(b_idx),        64'(e.bi));
`ifdef SYSTOLIC_CTRL_PERF_EN
            chk("perf_runs",    64'(perf_runs),    64'(e.runs));
            chk("perf_busy",    64'(perf_busy),    64'(e.bcyc));
`endif
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, compare on the
    // next falling edge.
    task automatic step(input logic st, input logic rs);
        start = st;
        reset = rs;
        model_edge(st, rs);
        sb_q.push_back(build_exp());
        @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    task automatic run_and_measure(input string tag);
        int lat;
        step(1'b1, 1'b0);
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin
            step(1'b0, 1'b0);
            lat++;
        end
        chk(tag, 64'(lat), 64'(T_TOTAL + 2));
    endtask

    task automatic drain_to_idle();
        int g;
        g = 0;
        while (ph != 0 && g < 40) begin
            step(1'b0, 1'b0);
            g++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ph       = 0;
        m_rv     = 1'b0;
        m_runs   = 0;
        m_busy   = 0;
        start    = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        // Reset state and quiet idle.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single run: timing and skew pattern, start-to-done latency.
        run_and_measure("latency_run1");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Start held high for 20 cycles: one run, then a second run whose
        // CLEAR drops result_valid.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
        end
        drain_to_idle();
        step(1'b0, 1'b0);

        // Starts pulsed during CLEAR/RUN/DONE (including the DONE cycle)
        // must be ignored.
        step(1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step(logic'(k % 2), 1'b0);
        end
        drain_to_idle();
        step(1'b0, 1'b0);

        // Reset in RUN at t=5: no done, outputs back to reset values.
        step(1'b1, 1'b0);
        for (int g = 0; g < 20 && ph != 7; g++) begin
            step(1'b0, 1'b0);
        end
        chk("reached_t5", 64'(ph), 64'd7);
        step(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
        end
        run_and_measure("latency_after_reset");
        step(1'b0, 1'b0);

        // Three back-to-back runs after a reset.
        step(1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b0);
            drain_to_idle();
        end
        step(1'b0, 1'b0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_runs_3", 64'(perf_runs), 64'd3);
        chk("perf_busy_39", 64'(perf_busy), 64'd39);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have parameter A_ROWS, default 4: rows of A and of the PE array.
REQ-002 The block SHALL have parameter A_COLS, default 4: the inner dimension, i.e. operands per row or column lane.
REQ-003 The block SHALL have parameter B_COLS, default 4: columns of B and of the PE array.
REQ-004 The block SHALL have parameter PE_LAT, default 1: PE MAC-to-result register latency in cycles, range 1..4.
REQ-005 The block SHALL have parameter IDX_W, default $clog2(A_COLS) (minimum 1): operand index width.
REQ-006 Port clk, input, 1 bit: the only clock; all logic SHALL be on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port start, input, 1 bit: single-cycle request to begin one matrix multiply.
REQ-009 Port busy, output, 1 bit: high while a multiply is in progress.
REQ-010 Port pe_clear, output, 1 bit: clears every PE accumulator.
REQ-011 Port a_valid, output, A_ROWS bits: per-row operand-valid into the array's left edge.
REQ-012 Port a_idx, output, A_ROWS*IDX_W bits: per-row k index into A; row i occupies slice [i*IDX_W +: IDX_W].
REQ-013 Port b_valid, output, B_COLS bits: per-column operand-valid into the array's top edge.
REQ-014 Port b_idx, output, B_COLS*IDX_W bits: per-column k index into B, packed the same way as a_idx.
REQ-015 Port done, output, 1 bit: one-cycle pulse when all results are final.
REQ-016 Port result_valid, output, 1 bit: the result matrix is stable and readable.

Function
REQ-017 The block SHALL implement the FSM states IDLE, CLEAR, RUN and DONE.
REQ-018 Transitions SHALL be IDLE->CLEAR on start=1, CLEAR->RUN unconditionally, RUN->DONE when t==T_TOTAL-1, and DONE->IDLE unconditionally.
REQ-019 T_TOTAL SHALL be A_COLS+A_ROWS+B_COLS-2+PE_LAT, computed at elaboration.
REQ-020 pe_clear SHALL be 1 only in CLEAR.
REQ-021 busy SHALL be 1 in CLEAR, RUN and DONE.
REQ-022 In RUN, the cycle counter t SHALL count 0..T_TOTAL-1, with t=0 in the first RUN cycle.
REQ-023 In RUN, a_valid[i] SHALL be 1 iff 0 <= t-i <= A_COLS-1, and a_idx for row i SHALL then equal t-i.
REQ-024 b_valid[j] and b_idx for column j SHALL follow the same rule with j in place of i.
REQ-025 When an operand is not valid, its index SHALL be driven to 0, and outside RUN all valids SHALL be 0.
REQ-026 done SHALL be 1 for exactly the single DONE cycle.
REQ-027 The block SHALL raise result_valid in the DONE cycle and hold it until a start is accepted, clearing it in the CLEAR cycle.
REQ-028 Latency from the start-sampling edge to done high SHALL be exactly T_TOTAL+2 cycles.
REQ-029 A start arriving in CLEAR, RUN or DONE SHALL be ignored: no queuing, no restart.
REQ-030 A start in the same cycle as done SHALL be ignored; the next accepted start is one sampled in IDLE.
REQ-031 Every output SHALL be registered, and no output SHALL depend combinationally on start.

Reset
REQ-032 On reset=1 at a rising edge, the block SHALL enter IDLE and clear t to 0.
REQ-033 Reset values SHALL be: busy, pe_clear, a_valid, b_valid, done and result_valid all 0; a_idx and b_idx all 0.
REQ-034 Reset SHALL take priority over start and over any state, including mid-RUN.
REQ-035 A reset during RUN SHALL produce no done pulse and SHALL leave result_valid at 0.

Configuration
REQ-036 Macro SYSTOLIC_CTRL_PERF_EN SHALL compile in a performance-counter feature; when it is undefined, the ports and counters SHALL be absent and the rest of the behaviour SHALL be identical.
REQ-037 When defined, the block SHALL add output perf_runs (16 bits), incremented on each done pulse and wrapping at 0xFFFF->0.
REQ-038 When defined, the block SHALL add output perf_busy (32 bits), incremented each cycle busy=1 and saturating at 0xFFFFFFFF.
REQ-039 reset SHALL clear both perf_runs and perf_busy to 0.

Structure
REQ-040 Package systolic_pkg SHALL hold the FSM state enum (2-bit) and a helper function computing T_TOTAL from the parameters.
REQ-041 Sub-module systolic_skew_lane SHALL be instantiated once per row and once per column, generating one lane's valid and idx from t and a lane offset parameter.

Verification (A_ROWS=A_COLS=B_COLS=4, PE_LAT=1, T_TOTAL=11)
REQ-042 Start sampled at edge 0 -> pe_clear=1 at cycle 1; RUN for cycles 2..12; done=1 at cycle 13 only; busy=1 for cycles 1..13.
REQ-043 Skew check in RUN -> t=0: a_valid=b_valid=0001; t=3: a_valid=1111 with row0 idx=3 and row3 idx=0; t=6: a_valid=1000 with row3 idx=3; t>=7: all valids 0 and all idx 0.
REQ-044 start held high for 20 cycles -> exactly one multiply runs; after done, start is still high in IDLE, so a second run begins and its CLEAR drops result_valid.
REQ-045 reset asserted at RUN t=5 -> next cycle all outputs are at reset values; done never pulses; a subsequent start yields done 13 cycles later.
REQ-046 With SYSTOLIC_CTRL_PERF_EN defined, 3 back-to-back runs -> perf_runs=3 and perf_busy=39; with the macro undefined, the build has no perf ports and REQ-042 still passes.
